// File: rtl/arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package arith_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a bit counter able to hold 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_seq_fa_bit.sv
// One-bit combinational full-adder cell.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial adder/subtractor: feeds operands LSB first through one
// full-adder cell, one bit per clock, and collects the result serially.
module serial_addsub_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int              CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             overflow_q;

    logic             sum_d;
    logic             carry_d;

    fa_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (sum_d),
        .cout (carry_d)
    );

    // Sequencer: operand capture, serial bit processing and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry.
                        a_q        <= a;
                        b_q        <= sub ? ~b : b;
                        carry_q    <= sub;
                        cnt_q      <= '0;
                        result_q   <= '0;
                        cout_q     <= 1'b0;
                        overflow_q <= 1'b0;
                        state_q    <= RUN;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    result_q <= {sum_d, result_q[WIDTH-1:1]};
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    carry_q  <= carry_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        // carry_q is the carry into the sign bit here.
                        cout_q     <= carry_d;
                        overflow_q <= carry_q ^ carry_d;
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Scoreboard bench for serial_addsub_seq with directed, hand-computed vectors.
module tb_serial_addsub_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    serial_addsub_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Edge counter used for latency checks.
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if ((busy & ready) !== 1'b0)
                    check("busy_ready_exclusive", 32'(busy & ready), 32'd0);
                if (done === 1'b1) begin
                    check("done_implies_ready", 32'(ready), 32'd1);
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("result",   32'(result),   32'(e.res));
                        check("cout",     32'(cout),     32'(e.co));
                        check("overflow", 32'(overflow), 32'(e.ov));
                        check("latency",  32'(cyc),      32'(e.cyc + W + 1));
                    end
                end
            end
        end
    end

    // Wait (bounded) for ready at a negedge, then present one start cycle.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                         input bit push, input logic [W-1:0] res, input logic co,
                         input logic ov);
        int n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
        start = 1'b1;
        a     = av;
        b     = bv;
        sub   = sv;
        if (push) sb.push_back('{res: res, co: co, ov: ov, cyc: cyc});
        @(negedge clk);
        start = 1'b0;
        a     = 8'hC3;
        b     = 8'h5A;
        sub   = ~sv;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Directed stimulus.
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready",    32'(ready),    32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_result",   32'(result),   32'd0);
        check("rst_cout",     32'(cout),     32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back sequence (each issue lands in the previous DONE cycle).
        issue(8'h5A, 8'h3C, 1'b0, 1, 8'h96, 1'b0, 1'b1);
        issue(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b0);
        issue(8'h10, 8'h20, 1'b1, 1, 8'hF0, 1'b0, 1'b0);
        issue(8'h80, 8'h01, 1'b1, 1, 8'h7F, 1'b1, 1'b1);
        issue(8'h7F, 8'h01, 1'b0, 1, 8'h80, 1'b0, 1'b1);
        issue(8'h00, 8'h00, 1'b1, 1, 8'h00, 1'b1, 1'b0);
        drain("drain_b2b");
        repeat (2) @(negedge clk);
        check("hold_result", 32'(result), 32'h00);
        check("hold_cout",   32'(cout),   32'd1);

        // Start during RUN must be ignored.
        issue(8'h12, 8'h34, 1'b0, 1, 8'h46, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("busy_in_run", 32'(busy), 32'd1);
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        drain("drain_ignored_start");
        repeat (12) @(negedge clk);
        check("hold_result2", 32'(result), 32'h46);

        // Reset mid-operation discards it.
        issue(8'h5A, 8'h3C, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready",    32'(ready),    32'd1);
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_done",     32'(done),     32'd0);
        check("midrst_result",   32'(result),   32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        repeat (12) @(negedge clk);

        // Operation after mid-run reset.
        issue(8'h37, 8'h21, 1'b0, 1, 8'h58, 1'b0, 1'b0);
        drain("drain_final");
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_addsub_seq.md
# serial_addsub_seq

Bit-serial adder/subtractor sequencer. Accepts two WIDTH-bit operands on a start pulse and feeds them through a single one-bit full-adder cell, LSB first, one bit per clock. It holds the carry between bits and assembles the result in a shift register. It sits beside the combinational adder cells as the area-minimal arithmetic path for slow control datapaths.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- sub  input  1  0 = a+b, 1 = a−b; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- ready  output  1  block can accept start (IDLE or DONE).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result/cout/overflow valid.
- result  output  WIDTH  sum/difference; held until next accepted start.
- cout  output  1  final carry out (for subtract: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow.

## Operation

- Reset values: ready=1, busy=0, done=0, result=0, cout=0, overflow=0; FSM=IDLE, bit counter=0, carry=0.
- FSM states:
  - IDLE: ready=1. Accepted start -> RUN.
  - RUN: busy=1, ready=0. Stays for exactly WIDTH cycles, then -> DONE.
  - DONE: done=1, ready=1 for one cycle. Start -> RUN (back-to-back); else -> IDLE.
- On accepted start:
  - a captured into shift register A.
  - b captured into shift register B, or ~b if sub=1.
  - carry initialised to sub (0 add, 1 subtract).
  - counter cleared; result register cleared.
- Each RUN cycle, the cell computes s = A[0]^B[0]^carry and c = majority(A[0],B[0],carry).
  - s shifts into result MSB while result shifts right.
  - carry<=c; A and B shift right; counter increments.
- Sign carry: on the last RUN bit (counter=WIDTH−1), the carry into that bit is kept.
  - overflow = carry_in_msb XOR carry_out_msb.
  - cout = final carry.
- Arithmetic is modulo 2^WIDTH. No saturation.
- start while busy=1 is ignored: no queuing, no effect on the current operation.
- sub, a and b are don't-care except in the accepting cycle.
- rst asserted in any state, including mid-RUN:
  - the next edge forces all reset values.
  - the in-flight operation is discarded and no done is issued.
- rst and start in the same cycle: rst wins; start is ignored.

## Timing

- Edge 0: start sampled with ready=1.
- Edges 1..WIDTH: bits 0..WIDTH−1 processed in RUN.
- Cycle after edge WIDTH: done=1, with result, cout and overflow valid. Latency from start is WIDTH+1 edges.
- Throughput: one operation per WIDTH+1 cycles using back-to-back start in DONE.
- result, cout and overflow:
  - stable from the done cycle until the edge after the next accepted start, when they clear.
  - intermediate values during RUN are not meaningful.
- busy and ready are mutually exclusive at all times. done implies ready.

## Structure

- Shared package (arith_pkg):
  - FSM state enum {IDLE, RUN, DONE}.
  - counter width constant CNT_W = $clog2(WIDTH+1).
- One sub-module is natural: fa_bit, a combinational one-bit full-adder cell (a, b, cin -> sum, cout). It is instantiated once; the controller owns all registers.
- No other hierarchy. All state is in a single clocked process using synchronous reset.

## Test plan

All scenarios use WIDTH=8.
- Add with signed overflow: a=0x5A, b=0x3C, sub=0 -> done at edge 9; result=0x96, cout=0, overflow=1.
- Add wrap: a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, overflow=0.
- Subtract with borrow: a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0, overflow=0.
- Subtract with signed overflow: a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, overflow=1.
- Start during RUN ignored: start on cycle 3 of RUN with a=0x01, b=0x01 -> original result unchanged, exactly one done pulse.
- Back-to-back operations:
  - start held during DONE accepts the second operation, which completes 9 edges later.
- Reset mid-operation:
  - rst in cycle 4 of RUN -> next cycle ready=1, busy=0, result=0, and no done pulse.
